kt_transpose_engine: RTL

- Upstream neighbour of the Q·K^T sequencer. Holds K (T rows × D_len cols, FP32 words) in an A buffer loaded by the CPU.
- On start, copies A[t][d] into B[d][t], producing K^T.
- Exposes B through a 1-cycle-latency read port, which the sequencer drains into the GEMM X SRAM.
- Copy runs at 1 element/cycle, pipelined read-then-write.

---
 rtl/kt_tr_pkg.sv | 23 ++
 rtl/kt_tr_sram.sv | 35 +++
 rtl/kt_transpose_engine.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/kt_tr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kt_tr_pkg
// Brief    : Shared types and width helpers for the K-transpose engine.
// Revision : 1.0
// ============================================================================
package kt_tr_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COPY  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/kt_tr_sram.sv
`default_nettype none
// ============================================================================
// Module   : kt_tr_sram
// Brief    : Single-clock 1R1W synchronous RAM with registered read data.
// Revision : 1.0
// ============================================================================
module kt_tr_sram
  import kt_tr_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = DATA_W_DEF,
  localparam int AW   = width_of(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Non-blocking update means a same-address read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/kt_transpose_engine.sv
`default_nettype none
// ============================================================================
// Module   : kt_transpose_engine
// Brief    : Copies K (A[t][d]) into K^T (B[d][t]) at one element per cycle
//            and serves B through a 1-cycle read port.
//            Optional: KT_TR_ROWMASK_EN zeroes B rows beyond the last
//            completed head dimension.
// Revision : 1.0
// ============================================================================
module kt_transpose_engine
  import kt_tr_pkg::*;
#(
  parameter int T       = 8,
  parameter int DMAX    = 1024,
  parameter int DATA_W  = DATA_W_DEF,
  localparam int T_W    = width_of(T),
  localparam int D_W    = width_of(DMAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       D_len,
  output logic              busy,
  output logic              done,
  input  logic              a_we,
  input  logic [T_W-1:0]    a_row,
  input  logic [D_W-1:0]    a_col,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_re,
  input  logic [31:0]       b_row,
  input  logic [31:0]       b_col,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid
);

  localparam int          A_AW    = width_of(T * DMAX);
  localparam int          B_AW    = width_of(DMAX * T);
  localparam logic [15:0] DMAX_16 = 16'(DMAX);
  localparam logic [15:0] T_LAST  = 16'(T - 1);

  state_t            r_state;
  logic [15:0]       r_t_cnt, r_d_cnt, r_d_lim;
  logic              r_wr_pend;
  logic [15:0]       r_wr_t, r_wr_d;
  logic              r_b_zero;

  logic [15:0]       w_d_eff;
  logic              w_a_we, w_a_re, w_last, w_b_oor;
  logic [A_AW-1:0]   w_a_waddr, w_a_raddr;
  logic [B_AW-1:0]   w_b_waddr, w_b_raddr;
  logic [DATA_W-1:0] w_a_rdata, w_b_rdata;

  assign w_d_eff   = (D_len > DMAX_16) ? DMAX_16 : D_len;
  assign w_last    = (r_t_cnt == T_LAST) && (r_d_cnt == r_d_lim - 16'd1);

  // A is frozen while the copy is in flight.
  assign w_a_we    = a_we && ((r_state == IDLE) || (r_state == FIN))
                     && (32'(a_row) < T) && (32'(a_col) < DMAX);
  assign w_a_re    = (r_state == COPY);
  assign w_a_waddr = A_AW'(32'(a_row) * DMAX + 32'(a_col));
  assign w_a_raddr = A_AW'(32'(r_t_cnt) * DMAX + 32'(r_d_cnt));
  assign w_b_waddr = B_AW'(32'(r_wr_d) * T + 32'(r_wr_t));
  assign w_b_raddr = B_AW'(b_row * T + b_col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      r_t_cnt   <= 16'd0;
      r_d_cnt   <= 16'd0;
      r_d_lim   <= 16'd0;
      r_wr_pend <= 1'b0;
      r_wr_t    <= 16'd0;
      r_wr_d    <= 16'd0;
    end else begin
      done      <= 1'b0;
      r_wr_pend <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_d_lim <= w_d_eff;
            r_t_cnt <= 16'd0;
            r_d_cnt <= 16'd0;
            if (w_d_eff == 16'd0) begin
              r_state <= FIN;
              done    <= 1'b1;
            end else begin
              r_state <= COPY;
              busy    <= 1'b1;
            end
          end
        end
        COPY: begin
          r_wr_pend <= 1'b1;
          r_wr_t    <= r_t_cnt;
          r_wr_d    <= r_d_cnt;
          if (r_t_cnt == T_LAST) begin
            r_t_cnt <= 16'd0;
            r_d_cnt <= r_d_cnt + 16'd1;
          end else begin
            r_t_cnt <= r_t_cnt + 16'd1;
          end
          if (w_last) r_state <= DRAIN;
        end
        DRAIN: begin
          r_state <= FIN;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef KT_TR_ROWMASK_EN
  logic [15:0] r_mask_lim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_mask_lim <= 16'd0;
    else if (r_state == FIN)  r_mask_lim <= r_d_lim;
  end

  assign w_b_oor = (b_row >= 32'(DMAX)) || (b_col >= 32'(T))
                   || (b_row >= {16'd0, r_mask_lim});
`else
  assign w_b_oor = (b_row >= 32'(DMAX)) || (b_col >= 32'(T));
`endif

  // Out-of-range reads still return a valid beat, forced to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_rvalid <= 1'b0;
      r_b_zero <= 1'b1;
    end else begin
      b_rvalid <= b_re;
      if (b_re) r_b_zero <= w_b_oor;
    end
  end

  assign b_rdata = r_b_zero ? '0 : w_b_rdata;

  kt_tr_sram #(.DEPTH(T * DMAX), .WIDTH(DATA_W)) u_a_ram (
    .clk     (clk),
    .i_we    (w_a_we),
    .i_waddr (w_a_waddr),
    .i_wdata (a_wdata),
    .i_re    (w_a_re),
    .i_raddr (w_a_raddr),
    .o_rdata (w_a_rdata)
  );

  kt_tr_sram #(.DEPTH(DMAX * T), .WIDTH(DATA_W)) u_b_ram (
    .clk     (clk),
    .i_we    (r_wr_pend),
    .i_waddr (w_b_waddr),
    .i_wdata (w_a_rdata),
    .i_re    (b_re),
    .i_raddr (w_b_raddr),
    .o_rdata (w_b_rdata)
  );

endmodule
`default_nettype wire
